// File: rtl/sum_stream_checker.sv
// Streaming sum checker: accumulates a run of beats and compares the total to a reference.
// Optional carry detection is built only when SUM_OVERFLOW_CHECK_EN is defined.
module sum_stream_checker #(
   parameter int DATA_WIDTH  = 32,
   parameter int SUM_WIDTH   = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] length,
   input  logic [SUM_WIDTH-1:0]   expected,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_pass,
   output logic [SUM_WIDTH-1:0]   res_sum,
   output logic [COUNT_WIDTH-1:0] res_count,
   output logic                   busy,
   output logic                   overflow,
   output logic [1:0]             fsm_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_RESULT = 2'd3;

   // in: valid/ready, a beat moves on in_valid & in_ready; result: held until res_valid & res_ready.
   logic [1:0]             state_q;
   logic [COUNT_WIDTH-1:0] len_q;
   logic [SUM_WIDTH-1:0]   exp_q;
   logic [SUM_WIDTH-1:0]   sum_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   pass_q;
   logic                   ovf;
   logic                   xfer;
   logic                   launch;
   logic [SUM_WIDTH-1:0]   sum_next;
   logic [COUNT_WIDTH-1:0] count_next;

   assign xfer       = in_valid && (state_q == S_ACCUM);
   assign launch     = start && (state_q == S_IDLE);
   assign count_next = count_q + COUNT_WIDTH'(1);

`ifdef SUM_OVERFLOW_CHECK_EN
   logic carry;

   assign {carry, sum_next} = {1'b0, sum_q} + {1'b0, SUM_WIDTH'(in_data)};

   // Sticky for the whole run; only a new start or reset clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (launch) begin
         ovf <= 1'b0;
      end else if (xfer && carry) begin
         ovf <= 1'b1;
      end
   end
`else
   assign sum_next = sum_q + SUM_WIDTH'(in_data);
   assign ovf      = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         exp_q   <= '0;
         sum_q   <= '0;
         count_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q   <= length;
                  exp_q   <= expected;
                  sum_q   <= '0;
                  count_q <= '0;
                  pass_q  <= 1'b0;
                  state_q <= (length == '0) ? S_CHECK : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (xfer) begin
                  sum_q   <= sum_next;
                  count_q <= count_next;
                  if (count_next == len_q) begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               pass_q  <= (sum_q == exp_q) && !ovf;
               state_q <= S_RESULT;
            end
            S_RESULT: begin
               // A start seen here is dropped: the block is not idle until the next cycle.
               if (res_ready) begin
                  pass_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_ACCUM);
   assign res_valid = (state_q == S_RESULT);
   assign busy      = (state_q != S_IDLE);
   assign res_pass  = pass_q;
   assign res_sum   = sum_q;
   assign res_count = count_q;
   assign overflow  = ovf;
   assign fsm_state = state_q;

endmodule
